// File: rtl/lsu_byte_access.sv
// rtl/lsu_byte_access.sv - byte/half/word load-store initiator onto a word-organised memory
// Sub-word stores read-modify-write the addressed word; loads extract and extend one lane.
module lsu_byte_access #(
  parameter int ADDR_W = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {IDLE, ERR, READ, WRITE, RESP} state_t;

  state_t      state, state_next;
  logic        wr_q, sgn_q;
  logic [1:0]  size_q, lane_q;
  logic [31:0] wdata_q, buf_q, mem_addr_q;
  logic        req_err;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] load_data, merged;

  always_comb begin
    req_err = 1'b0;
    case (req_size)
      2'd1:    req_err = req_addr[0];
      2'd2:    req_err = |req_addr[1:0];
      2'd3:    req_err = 1'b1;
      default: req_err = 1'b0;
    endcase
    if ((req_addr >> (ADDR_W + 2)) != 32'd0) req_err = 1'b1;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (req_err)                         state_next = ERR;
          else if (req_write && req_size == 2'd2) state_next = WRITE;
          else                                 state_next = READ;
        end
      end
      READ:    state_next = wr_q ? WRITE : RESP;
      WRITE:   state_next = RESP;
      RESP:    state_next = IDLE;
      ERR:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      mem_addr_q <= 32'd0;
    end else begin
      state <= state_next;
      // Only accepted, legal requests move the memory address; errors leave it alone.
      if (state == IDLE && req_valid && !req_err)
        mem_addr_q <= 32'(req_addr[ADDR_W+1:2]);
    end
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && req_valid) begin
      wr_q    <= req_write;
      size_q  <= req_size;
      sgn_q   <= req_signed;
      lane_q  <= req_addr[1:0];
      wdata_q <= req_wdata;
    end
    if (state == READ) buf_q <= mem_rdata;
  end

  always_comb begin
    byte_lane = 8'd0;
    half_lane = 16'd0;
    load_data = buf_q;
    case (lane_q)
      2'd0:    byte_lane = buf_q[7:0];
      2'd1:    byte_lane = buf_q[15:8];
      2'd2:    byte_lane = buf_q[23:16];
      default: byte_lane = buf_q[31:24];
    endcase
    half_lane = lane_q[1] ? buf_q[31:16] : buf_q[15:0];
    case (size_q)
      2'd0:    load_data = {{24{sgn_q & byte_lane[7]}}, byte_lane};
      2'd1:    load_data = {{16{sgn_q & half_lane[15]}}, half_lane};
      default: load_data = buf_q;
    endcase
  end

  always_comb begin
    merged = buf_q;
    if (size_q == 2'd0) begin
      case (lane_q)
        2'd0:    merged[7:0]   = wdata_q[7:0];
        2'd1:    merged[15:8]  = wdata_q[7:0];
        2'd2:    merged[23:16] = wdata_q[7:0];
        default: merged[31:24] = wdata_q[7:0];
      endcase
    end else if (lane_q[1]) begin
      merged[31:16] = wdata_q[15:0];
    end else begin
      merged[15:0] = wdata_q[15:0];
    end
  end

  assign req_ready  = (state == IDLE) && !reset;
  assign resp_valid = (state == RESP) || (state == ERR);
  assign resp_err   = (state == ERR);
  assign resp_rdata = (state == RESP && !wr_q) ? load_data : 32'd0;
  assign mem_we     = (state == WRITE);
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = (state == WRITE) ? ((size_q == 2'd2) ? wdata_q : merged) : 32'd0;

endmodule

// File: tb/tb_lsu_byte_access.sv
// tb/tb_lsu_byte_access.sv - randomized self-checking bench for lsu_byte_access
// A transaction-level model predicts each cycle's outputs; one negedge process compares.
module tb_lsu_byte_access;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err, mem_we;
  logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;

  logic [31:0] mem     [0:65535];
  logic [31:0] ref_mem [0:65535];

  typedef struct {
    logic        valid, err, ready, we, chk_addr;
    logic [31:0] rdata, addr, wdata;
  } exp_t;
  exp_t q[$];

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] last_rdata;

  lsu_byte_access #(.ADDR_W(16)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_err(resp_err),
    .resp_rdata(resp_rdata), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[15:0]];
  always @(posedge clk) if (mem_we) mem[mem_addr[15:0]] <= mem_wdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic v, input logic e, input logic [31:0] rd, input logic rdy,
                      input logic we, input logic ca, input logic [31:0] a, input logic [31:0] wd);
    exp_t x;
    x.valid = v; x.err = e; x.rdata = rd; x.ready = rdy;
    x.we = we; x.chk_addr = ca; x.addr = a; x.wdata = wd;
    q.push_back(x);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin : cmp
      exp_t e;
      e = q.pop_front();
      chk("resp_valid", 32'(resp_valid), 32'(e.valid));
      chk("req_ready", 32'(req_ready), 32'(e.ready));
      chk("mem_we", 32'(mem_we), 32'(e.we));
      if (e.valid) begin
        chk("resp_err", 32'(resp_err), 32'(e.err));
        chk("resp_rdata", resp_rdata, e.rdata);
        last_rdata = resp_rdata;
      end
      if (e.chk_addr) chk("mem_addr", mem_addr, e.addr);
      if (e.we) chk("mem_wdata", mem_wdata, e.wdata);
    end
  end

  task automatic wait_drain();
    for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      chk("drain_timeout", 32'(q.size()), 32'd0);
      q.delete();
    end
    #1;
  endtask

  task automatic do_req(input logic w, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd, input logic garbage);
    logic        err;
    logic [31:0] widx, old, lane, mask, nw;
    int          sh, lat;
    wait_drain();
    req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd;

    err  = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0) ||
           (a >= 32'h0004_0000);
    widx = a >> 2;
    sh   = 8 * int'(a[1:0]);
    mask = (sz == 2'd0) ? 32'hFF : (sz == 2'd1) ? 32'hFFFF : 32'hFFFF_FFFF;
    old  = err ? 32'd0 : ref_mem[widx[15:0]];
    lane = (old >> sh) & mask;
    if (sg && sz == 2'd0 && lane[7])  lane = lane | 32'hFFFF_FF00;
    if (sg && sz == 2'd1 && lane[15]) lane = lane | 32'hFFFF_0000;
    nw   = (old & ~(mask << sh)) | ((wd & mask) << sh);

    @(posedge clk); #1;
    if (err) begin
      lat = 1;
      push(1, 1, 0, 0, 0, 0, 0, 0);
    end else if (!w) begin
      lat = 2;
      push(0, 0, 0, 0, 0, 1, widx, 0);
      push(1, 0, lane, 0, 0, 0, 0, 0);
    end else if (sz == 2'd2) begin
      lat = 2;
      push(0, 0, 0, 0, 1, 1, widx, nw);
      push(1, 0, 0, 0, 0, 0, 0, 0);
      ref_mem[widx[15:0]] = nw;
    end else begin
      lat = 3;
      push(0, 0, 0, 0, 0, 1, widx, 0);
      push(0, 0, 0, 0, 1, 1, widx, nw);
      push(1, 0, 0, 0, 0, 0, 0, 0);
      ref_mem[widx[15:0]] = nw;
    end
    push(0, 0, 0, 1, 0, 0, 0, 0);

    if (garbage) begin
      req_write = 1'($urandom); req_size = 2'($urandom); req_signed = 1'($urandom);
      req_addr = $urandom; req_wdata = $urandom;
      repeat (lat) @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
    req_signed = 1'b0; req_addr = 32'd0; req_wdata = 32'd0; last_rdata = 32'd0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_resp_valid", 32'(resp_valid), 0);
    chk("rst_resp_err", 32'(resp_err), 0);
    chk("rst_resp_rdata", resp_rdata, 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", 32'(req_ready), 1);
    #1;

    for (int i = 0; i < 16; i++) do_req(1, 2'd2, 0, 32'h100 + 32'(4 * i), $urandom, 0);

    do_req(1, 2'd2, 0, 32'h100, 32'hDEAD_BEEF, 0);
    wait_drain();
    chk("lit_sw_mem", mem[16'h40], 32'hDEAD_BEEF);
    do_req(0, 2'd2, 0, 32'h100, 0, 0);
    wait_drain();
    chk("lit_lw", last_rdata, 32'hDEAD_BEEF);

    do_req(1, 2'd2, 0, 32'h100, 32'h1122_3344, 0);
    do_req(1, 2'd2, 0, 32'h104, 32'hCAFE_1234, 0);
    do_req(1, 2'd0, 0, 32'h102, 32'h0000_00A5, 0);
    wait_drain();
    chk("lit_sb_mem", mem[16'h40], 32'h11A5_3344);
    do_req(0, 2'd0, 1, 32'h102, 0, 0); wait_drain();
    chk("lit_lb", last_rdata, 32'hFFFF_FFA5);
    do_req(0, 2'd0, 0, 32'h102, 0, 0); wait_drain();
    chk("lit_lbu", last_rdata, 32'h0000_00A5);

    do_req(1, 2'd1, 0, 32'h106, 32'h0000_8001, 0);
    wait_drain();
    chk("lit_sh_mem", mem[16'h41], 32'h8001_1234);
    do_req(0, 2'd1, 1, 32'h106, 0, 0); wait_drain();
    chk("lit_lh", last_rdata, 32'hFFFF_8001);
    do_req(0, 2'd1, 0, 32'h106, 0, 0); wait_drain();
    chk("lit_lhu", last_rdata, 32'h0000_8001);

    do_req(1, 2'd1, 0, 32'h101, 32'h1, 0);
    do_req(1, 2'd2, 0, 32'h102, 32'h2, 0);
    do_req(1, 2'd3, 0, 32'h100, 32'h3, 0);
    do_req(1, 2'd2, 0, 32'h0004_0000, 32'h4, 0);
    do_req(0, 2'd2, 0, 32'h0004_0000, 0, 0);
    wait_drain();
    chk("lit_err_mem", mem[16'h40], 32'h11A5_3344);

    // Abort a byte store by resetting during its READ cycle.
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_signed = 1'b0;
    req_addr = 32'h108; req_wdata = 32'h5A;
    @(posedge clk); #1;
    req_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort_mem_we", 32'(mem_we), 0);
      chk("abort_resp_valid", 32'(resp_valid), 0);
    end
    chk("abort_mem", mem[16'h42], ref_mem[16'h42]);
    #1;
    do_req(0, 2'd0, 0, 32'h108, 0, 0);
    do_req(1, 2'd0, 0, 32'h109, 32'h77, 0);

    for (int i = 0; i < 300; i++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 7) == 0) ? $urandom : 32'h100 + 32'($urandom_range(0, 63));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      #1;
      do_req(1'($urandom), 2'($urandom), 1'($urandom), a, $urandom, 1'($urandom));
    end
    wait_drain();
    for (int i = 0; i < 16; i++) chk("final_mem", mem[16'h40 + i], ref_mem[16'h40 + i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
